fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0: first instruction address after reset.
REQ-002 The block SHALL have parameter MEM_SIZE, default 4095: instruction memory size in bytes, used for range checks.
REQ-003 Port clk SHALL be an input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 Port stall SHALL be an input, 1 bit: the consumer cannot accept out_* this cycle.
REQ-006 Port redirect_valid SHALL be an input, 1 bit: a taken branch or jump from a later stage.
REQ-007 Port redirect_pc SHALL be an input, 64 bits: target address; valid only when redirect_valid=1.
REQ-008 Port imem_addr SHALL be an output, 64 bits: byte address to the instruction memory; the memory registers its read, so data returns one cycle later.
REQ-009 Port imem_instr SHALL be an input, 32 bits: little-endian word for the address presented on the previous cycle.
REQ-010 Port out_valid SHALL be an output, 1 bit: out_pc/out_instr form a valid fetched instruction.
REQ-011 Port out_pc SHALL be an output, 64 bits: address of out_instr.
REQ-012 Port out_pc_plus4 SHALL be an output, 64 bits: out_pc+4.
REQ-013 Port out_instr SHALL be an output, 32 bits: the fetched instruction (imem_instr passed through).
REQ-014 Port halted SHALL be an output, 1 bit: the fetch unit has stopped permanently until reset.
REQ-015 Port fault SHALL be an output, 2 bits: halt cause. 00 = end of program or none; 01 = misaligned target; 10 = address out of range.
REQ-016 Port fetch_count SHALL be an output, 32 bits: number of instructions accepted by the consumer.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and HALT.
REQ-018 The block SHALL keep registers fetch_pc_q (64 bits) and valid_q (1 bit), which record the address issued last cycle.
REQ-019 In IDLE, next_addr SHALL be RESET_PC.
REQ-020 In RUN, next_addr SHALL be selected by priority: redirect_valid gives redirect_pc; otherwise stall gives fetch_pc_q, re-reading the held word; otherwise fetch_pc_q+4.
REQ-021 imem_addr SHALL equal next_addr combinationally in IDLE and RUN; in HALT it SHALL equal fetch_pc_q.
REQ-022 Address check: if next_addr[1:0]!=0, the block SHALL go to HALT with fault=01 and no issue.
REQ-023 Address check: if next_addr+3 > MEM_SIZE-1, the block SHALL go to HALT with fault=10 and no issue.
REQ-024 Address check: if next_addr passes both checks, on the clock edge fetch_pc_q SHALL take next_addr and valid_q SHALL become 1.
REQ-025 IDLE SHALL go to RUN after one cycle if RESET_PC passes the address check.
REQ-026 out_valid SHALL equal valid_q AND state==RUN AND NOT redirect_valid AND imem_instr!=0.
REQ-027 out_pc SHALL be fetch_pc_q, and out_instr SHALL be imem_instr.
REQ-028 Latency: the first out_valid SHALL occur on the 2nd rising edge after reset deasserts (IDLE edge, then the fetch edge).
REQ-029 Handshake: an instruction SHALL be accepted when out_valid=1 and stall=0, and fetch_count SHALL then increment, wrapping at 2^32.
REQ-030 While stalled, out_pc and out_instr SHALL stay stable on every cycle.
REQ-031 A redirect SHALL squash the current output (out_valid=0 that cycle), and the target SHALL appear the next cycle with zero bubbles.
REQ-032 A redirect SHALL take priority over a stall in the same cycle.
REQ-033 In RUN with valid_q=1, redirect_valid=0 and imem_instr==0, the block SHALL go to HALT with fault=00 (end of program).
REQ-034 A zero word seen while redirect_valid=1 SHALL NOT halt.
REQ-035 HALT SHALL be terminal: out_valid=0, halted=1, and redirect and stall ignored; it SHALL be left only by reset.

Reset
REQ-036 While reset=0, the outputs SHALL be: state=IDLE, fetch_pc_q=RESET_PC, valid_q=0, out_valid=0, halted=0, fault=00, fetch_count=0.
REQ-037 Reset asserted mid-operation SHALL take effect immediately and asynchronously, dropping out_valid in the same cycle.
REQ-038 After reset, fetch SHALL restart from RESET_PC.

Structure
REQ-039 Shared package fetch_pkg SHALL hold the state encoding, the fault codes (FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE) and INSTR_BYTES=4.
REQ-040 The address check SHALL be a sub-module, fetch_addr_check (combinational: addr in, misaligned and out_of_range out).
REQ-041 Everything else SHALL be in a single module of 120-400 lines.

Verification
REQ-042 Memory holding 3 nonzero words, then 0; no stall -> out_pc 0,4,8 valid on consecutive cycles, then halted=1, fault=00, fetch_count=3.
REQ-043 stall=1 for 3 cycles while out_pc=4 -> out_pc=4 with the same instr held; after the stall, 8 follows; fetch_count counts 4 once.
REQ-044 redirect_valid=1, redirect_pc=0x40 while out_pc=8 -> out_valid=0 that cycle; next cycle out_pc=0x40 valid; redirect with stall=1 behaves the same.
REQ-045 redirect_pc=0x42 -> halted=1, fault=01, out_valid=0 thereafter.
REQ-046 MEM_SIZE=16 and sequential fetch to 0xC -> fetch of 0x10 refused, halted=1, fault=10.
REQ-047 reset=0 asserted mid-run -> out_valid=0 immediately; after release, the first out_pc=RESET_PC on the 2nd edge, fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, halt causes
// and instruction width.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for an instruction fetch address: word alignment
// and whether the whole instruction lies inside the memory.
module fetch_addr_check
  import fetch_pkg::*;
#(
  parameter logic [63:0] MEM_SIZE = 64'd4095
) (
  input  logic [63:0] addr_i,
  output logic        misaligned_o,
  output logic        out_of_range_o
);

  // Widened by one bit so addresses near 2^64 cannot wrap past the limit.
  logic [64:0] last_byte;

  assign last_byte      = {1'b0, addr_i} + 65'(INSTR_BYTES - 1);
  assign misaligned_o   = (addr_i[1:0] != 2'b00);
  // last_byte > MEM_SIZE-1, written so that MEM_SIZE == 0 rejects everything.
  assign out_of_range_o = (last_byte >= {1'b0, MEM_SIZE});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues addresses to a registered-read instruction
// memory, presents fetched words with a valid/stall handshake, and halts on faults.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] MEM_SIZE = 64'd4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc_plus4,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic         valid_q, valid_d;
  logic [1:0]   fault_q, fault_d;
  logic [31:0]  count_q, count_d;

  logic [63:0]  next_addr;
  logic         misaligned;
  logic         out_of_range;
  logic         end_of_prog;

  fetch_addr_check #(
    .MEM_SIZE(MEM_SIZE)
  ) u_addr_check (
    .addr_i        (next_addr),
    .misaligned_o  (misaligned),
    .out_of_range_o(out_of_range)
  );

  always_comb begin
    next_addr = RESET_PC;
    unique case (state_q)
      StIdle: next_addr = RESET_PC;
      StRun: begin
        if (redirect_valid) begin
          next_addr = redirect_pc;
        end else if (stall) begin
          next_addr = fetch_pc_q;
        end else begin
          next_addr = fetch_pc_q + 64'(INSTR_BYTES);
        end
      end
      StHalt: next_addr = fetch_pc_q;
      default: next_addr = RESET_PC;
    endcase
  end

  assign imem_addr = (state_q == StHalt) ? fetch_pc_q : next_addr;

  // A zero word under a redirect belongs to the squashed path and must not halt.
  assign end_of_prog = (state_q == StRun) && valid_q && !redirect_valid &&
                       (imem_instr == 32'h0);

  assign out_valid    = valid_q && (state_q == StRun) && !redirect_valid &&
                        (imem_instr != 32'h0);
  assign out_pc       = fetch_pc_q;
  assign out_pc_plus4 = fetch_pc_q + 64'(INSTR_BYTES);
  assign out_instr    = imem_instr;
  assign halted       = (state_q == StHalt);
  assign fault        = fault_q;
  assign fetch_count  = count_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    count_d    = count_q;

    if (out_valid && !stall) begin
      count_d = count_q + 32'd1;
    end

    if (state_q != StHalt) begin
      if (end_of_prog) begin
        state_d = StHalt;
        fault_d = FAULT_NONE;
        valid_d = 1'b0;
      end else if (misaligned) begin
        state_d = StHalt;
        fault_d = FAULT_MISALIGN;
        valid_d = 1'b0;
      end else if (out_of_range) begin
        state_d = StHalt;
        fault_d = FAULT_RANGE;
        valid_d = 1'b0;
      end else begin
        state_d    = StRun;
        fetch_pc_d = next_addr;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      fault_q    <= FAULT_NONE;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

endmodule
